// File: rtl/mem_param_if.sv
// Request/response bus of the mem_param word memory.
// The master issues requests; the slave (the memory) returns a one-cycle
// response pulse together with read data and error status.
interface mem_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     data_out;
  logic                  err;
  logic [7:0]            err_count;
  logic                  busy;

  modport master (
    output req_valid, read, write, addr, data_in, be,
    input  req_ready, rsp_valid, data_out, err, err_count, busy
  );

  modport slave (
    input  req_valid, read, write, addr, data_in, be,
    output req_ready, rsp_valid, data_out, err, err_count, busy
  );
endinterface

// File: rtl/mem_param.sv
// mem_param: single-port word memory with byte-enabled writes, latency-1
// registered reads, illegal-request detection with a saturating error
// counter, and an optional zero-fill sequence after reset.
module mem_param #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 5,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_param_if.slave    bus
);

  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Reset lands in CLEAR only when a zero-fill is wanted.
  localparam state_t            RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // One bit wider than the address so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  // Replace only the enabled bytes of a stored word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NBYTES-1:0] byte_en
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                r_rsp_valid;
  logic                r_err;
  logic [DATA_W-1:0]   r_data_out;
  logic [7:0]          r_err_count;

  logic                w_req_ready;
  logic                w_busy;
  logic                w_accept;
  logic                w_legal;
  logic                w_rd_en;
  logic                w_wr_en;
  logic                w_clr_en;
  logic [ADDR_W-1:0]   w_mem_idx;
  logic [DATA_W-1:0]   w_wr_word;

  // FSM state register: reset restarts any fill from the beginning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: CLEAR lasts exactly DEPTH cycles, READY is terminal.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_addr == LAST_ADDR) begin
          w_next_state = ST_READY;
        end else begin
          w_next_state = ST_CLEAR;
        end
      end
      ST_READY: w_next_state = ST_READY;
      default:  w_next_state = RST_STATE;
    endcase
  end

  // FSM outputs: ready is also held low while reset is asserted so no
  // request can slip in with CLEAR_ON_RST=0.
  always_comb begin
    w_req_ready = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_req_ready = 1'b0;
        w_busy      = 1'b1;
      end
      ST_READY: begin
        if (rst) begin
          w_req_ready = 1'b0;
        end else begin
          w_req_ready = 1'b1;
        end
        w_busy = 1'b0;
      end
      default: begin
        w_req_ready = 1'b0;
        w_busy      = 1'b0;
      end
    endcase
  end

  // Fill address counter, advancing one word per CLEAR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_addr <= {ADDR_W{1'b0}};
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_addr == LAST_ADDR) begin
        r_clr_addr <= {ADDR_W{1'b0}};
      end else begin
        r_clr_addr <= r_clr_addr + ADDR_W'(1);
      end
    end else begin
      r_clr_addr <= {ADDR_W{1'b0}};
    end
  end

  // Request decode: legality, access enables and the merged write word.
  always_comb begin
    w_accept = bus.req_valid && w_req_ready;
    if ((bus.read != bus.write) && ({1'b0, bus.addr} < DEPTH_X)) begin
      w_legal   = 1'b1;
      w_mem_idx = bus.addr;
    end else begin
      w_legal   = 1'b0;
      w_mem_idx = {ADDR_W{1'b0}};
    end
    w_rd_en = w_accept && w_legal && bus.read;
    w_wr_en = w_accept && w_legal && bus.write;
    if (r_state == ST_CLEAR) begin
      w_clr_en = !rst;
    end else begin
      w_clr_en = 1'b0;
    end
    w_wr_word = merge_bytes(r_mem[w_mem_idx], bus.data_in, bus.be);
  end

  // Storage array: no reset so that reset alone never alters contents.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[r_clr_addr] <= {DATA_W{1'b0}};
    end else if (w_wr_en) begin
      r_mem[w_mem_idx] <= w_wr_word;
    end
  end

  // Response path: pulses, read data and the saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_data_out  <= {DATA_W{1'b0}};
      r_err_count <= 8'd0;
    end else begin
      r_rsp_valid <= w_accept;
      r_err       <= w_accept && !w_legal;
      if (w_rd_en) begin
        r_data_out <= r_mem[w_mem_idx];
      end
      if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.busy      = w_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.err       = r_err;
  assign bus.data_out  = r_data_out;
  assign bus.err_count = r_err_count;

endmodule

// File: doc/mem_param.md
MEM_PARAM -- requirements
Module: mem_param

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 32: number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-003 Parameter ADDR_W, default 5: address width in bits.
REQ-004 Parameter CLEAR_ON_RST, default 1: 1 means zero-fill the array after reset; 0 means skip the fill.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 read  input  1  read command.
REQ-010 write  input  1  write command.
REQ-011 addr  input  ADDR_W  word address.
REQ-012 data_in  input  DATA_W  write data.
REQ-013 be  input  DATA_W/8  byte enables for writes; be[i] gates data_in[8i+7:8i].
REQ-014 rsp_valid  output  1  one-cycle pulse completing an accepted request.
REQ-015 data_out  output  DATA_W  read data.
REQ-016 err  output  1  one-cycle pulse: the accepted request was illegal.
REQ-017 err_count  output  8  saturating count of illegal requests.
REQ-018 busy  output  1  high while the clear sequence runs.

Function
REQ-019 The FSM SHALL have two states, CLEAR and READY; req_ready=(state==READY); busy=(state==CLEAR).
REQ-020 CLEAR (entered from reset, CLEAR_ON_RST=1) SHALL write 0 to one word per cycle, addresses 0..DEPTH-1 ascending, then enter READY after exactly DEPTH cycles.
REQ-021 With CLEAR_ON_RST=0, the block SHALL leave reset directly in READY; array contents stay undefined.
REQ-022 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-023 Legal read is read=1, write=0, addr<DEPTH: data_out SHALL take memory[addr] and rsp_valid SHALL be 1 in the cycle after acceptance (latency 1).
REQ-024 Legal write is write=1, read=0, addr<DEPTH: each byte with be[i]=1 SHALL be updated; bytes with be[i]=0 SHALL keep their value; rsp_valid SHALL pulse next cycle and data_out SHALL hold.
REQ-025 Illegal request is read==write, or addr>=DEPTH: no array change, data_out holds, rsp_valid and err SHALL pulse together next cycle, and err_count SHALL increment, saturating at 255.
REQ-026 A write with be all zero SHALL be legal and leave the array unchanged.
REQ-027 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-028 The block SHALL accept back-to-back requests every cycle in READY; there is no back-pressure on the response.
REQ-029 While not READY, req_valid SHALL be ignored: no array access, no pulse, no count.

Reset
REQ-030 While rst=1, outputs SHALL be data_out=0, rsp_valid=0, err=0, err_count=0, req_ready=0, busy=CLEAR_ON_RST; state SHALL be CLEAR (or READY if CLEAR_ON_RST=0).
REQ-031 rst asserted mid-clear SHALL abort the clear; after deassertion, the clear SHALL restart from address 0 and take the full DEPTH cycles.
REQ-032 rst SHALL NOT itself modify array contents; only the clear sequence does.
REQ-033 An outstanding response SHALL be dropped on rst; no rsp_valid SHALL follow.

Verification (DATA_W=16, DEPTH=24, ADDR_W=5 unless stated)
REQ-034 Release rst -> busy=1 and req_ready=0 for 24 cycles, then req_ready=1; reads of addresses 0..23 return 0x0000.
REQ-035 Write 0xABCD to addr 5 with be=2'b01, then read addr 5 -> data_out=0x00CD with rsp_valid one cycle after the read is accepted.
REQ-036 Write 0x1234 to addr 7, read addr 7 on the next cycle -> data_out=0x1234; back-to-back accepts with no idle cycle.
REQ-037 Read addr 24; request read=1,write=1; request read=0,write=0 -> three err pulses, err_count=3, array and data_out unchanged; 300 illegal requests -> err_count=255.
REQ-038 Assert rst at clear cycle 10, release -> busy stays high for a further full 24 cycles; no rsp_valid appears.
REQ-039 CLEAR_ON_RST=0: release rst -> req_ready=1 on the first edge; write then read addr 0 returns the written value.
